// File: rtl/hdmi_pkg.sv
// Shared definitions for the 640x480@60 RGB333 frame buffer: default video
// timing, frame-buffer size, RGB333 word layout and colour expansion.
package hdmi_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FB_WORDS = H_ACTIVE * V_ACTIVE;

  localparam int unsigned COMP_W = 3;
  localparam int unsigned PIX_W  = 3 * COMP_W;

  // One frame-buffer word, {R[2:0],G[2:0],B[2:0]}
  typedef struct packed {
    logic [COMP_W-1:0] r;
    logic [COMP_W-1:0] g;
    logic [COMP_W-1:0] b;
  } rgb333_t;

  // Per-pixel control flags carried alongside the data pipeline
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } vid_ctl_t;

  // 3-bit to 8-bit by bit replication so full scale maps to 8'hFF
  function automatic logic [7:0] expand3(input logic [COMP_W-1:0] c);
    return {c, c, c[2:1]};
  endfunction

endpackage

// File: rtl/video_timing.sv
// Horizontal/vertical raster counters and the region flags derived from them.
// Ports: clk/rst (async active-high); *_c flags are combinational from the
// counter registers: active, hsync/vsync region, first pixel, active at the
// next position, and end-of-frame wrap.
module video_timing #(
  parameter int unsigned H_ACTIVE = hdmi_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = hdmi_pkg::H_FP,
  parameter int unsigned H_SYNC   = hdmi_pkg::H_SYNC,
  parameter int unsigned H_BP     = hdmi_pkg::H_BP,
  parameter int unsigned V_ACTIVE = hdmi_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = hdmi_pkg::V_FP,
  parameter int unsigned V_SYNC   = hdmi_pkg::V_SYNC,
  parameter int unsigned V_BP     = hdmi_pkg::V_BP
) (
  input  logic clk,
  input  logic rst,
  output logic active_c,
  output logic active_nxt_c,
  output logic hsync_act_c,
  output logic vsync_act_c,
  output logic first_c,
  output logic frame_wrap_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = $clog2(H_TOTAL);
  localparam int unsigned V_W     = $clog2(V_TOTAL);

  logic [H_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_W-1:0] v_cnt_q, v_cnt_d;
  logic           line_end;
  logic           frame_end;

  // Next raster position; v advances when h wraps, both wrap at frame end
  always_comb begin
    line_end  = (h_cnt_q == H_W'(H_TOTAL - 1));
    frame_end = line_end && (v_cnt_q == V_W'(V_TOTAL - 1));
    h_cnt_d   = line_end ? '0 : h_cnt_q + H_W'(1);
    v_cnt_d   = v_cnt_q;
    if (frame_end) begin
      v_cnt_d = '0;
    end else if (line_end) begin
      v_cnt_d = v_cnt_q + V_W'(1);
    end
  end

  // Region flags for the current position (and active for the next one)
  always_comb begin
    active_c     = (h_cnt_q < H_W'(H_ACTIVE)) && (v_cnt_q < V_W'(V_ACTIVE));
    active_nxt_c = (h_cnt_d < H_W'(H_ACTIVE)) && (v_cnt_d < V_W'(V_ACTIVE));
    hsync_act_c  = (h_cnt_q >= H_W'(H_ACTIVE + H_FP)) &&
                   (h_cnt_q <  H_W'(H_ACTIVE + H_FP + H_SYNC));
    vsync_act_c  = (v_cnt_q >= V_W'(V_ACTIVE + V_FP)) &&
                   (v_cnt_q <  V_W'(V_ACTIVE + V_FP + V_SYNC));
    first_c      = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_wrap_c = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/hdmi_scanout.sv
// Frame-buffer scan-out: raster timing, linear read address, two-stage
// alignment of data and sync, RGB333 -> RGB888 expansion.
// Ports: rdclk/reset (async active-high); rdaddress to the buffer;
// read_data returns one rdclk later; red/green/blue/hsync/vsync/de and
// frame_start are registered and mutually aligned.
module hdmi_scanout
  import hdmi_pkg::rgb333_t, hdmi_pkg::vid_ctl_t, hdmi_pkg::expand3;
#(
  parameter int unsigned H_ACTIVE = hdmi_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = hdmi_pkg::H_FP,
  parameter int unsigned H_SYNC   = hdmi_pkg::H_SYNC,
  parameter int unsigned H_BP     = hdmi_pkg::H_BP,
  parameter int unsigned V_ACTIVE = hdmi_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = hdmi_pkg::V_FP,
  parameter int unsigned V_SYNC   = hdmi_pkg::V_SYNC,
  parameter int unsigned V_BP     = hdmi_pkg::V_BP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              rdclk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [8:0]        read_data,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  logic active_c, active_nxt_c, hsync_act_c, vsync_act_c, first_c, frame_wrap_c;

  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk         (rdclk),
    .rst         (reset),
    .active_c    (active_c),
    .active_nxt_c(active_nxt_c),
    .hsync_act_c (hsync_act_c),
    .vsync_act_c (vsync_act_c),
    .first_c     (first_c),
    .frame_wrap_c(frame_wrap_c)
  );

  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
  vid_ctl_t          ctl_s1_q, ctl_s1_d;
  logic              de_q, de_d;
  logic              fs_q, fs_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic [7:0]        red_q, red_d;
  logic [7:0]        green_q, green_d;
  logic [7:0]        blue_q, blue_d;
  rgb333_t           pix;

  always_comb begin
    // Address counter: advances on active pixels, holds through blanking
    addr_cnt_d = addr_cnt_q;
    if (frame_wrap_c) begin
      addr_cnt_d = '0;
    end else if (active_c) begin
      addr_cnt_d = addr_cnt_q + ADDR_W'(1);
    end
    // Registered so rdaddress matches the position the counters will hold;
    // masked outside active video so the held end-of-frame count never shows
    rdaddress_d = active_nxt_c ? addr_cnt_d : '0;

    // Stage 1: flags wait alongside the buffer's own read register
    ctl_s1_d = '{de: active_c, hs: hsync_act_c, vs: vsync_act_c, fs: first_c};

    // Stage 2: output register, colour forced to black outside active video
    pix     = rgb333_t'(read_data);
    de_d    = ctl_s1_q.de;
    fs_d    = ctl_s1_q.fs;
    hsync_d = ctl_s1_q.hs ? SYNC_POL : ~SYNC_POL;
    vsync_d = ctl_s1_q.vs ? SYNC_POL : ~SYNC_POL;
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (ctl_s1_q.de) begin
      red_d   = expand3(pix.r);
      green_d = expand3(pix.g);
      blue_d  = expand3(pix.b);
    end
  end

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      addr_cnt_q  <= '0;
      rdaddress_q <= '0;
      ctl_s1_q    <= '0;
      de_q        <= 1'b0;
      fs_q        <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      addr_cnt_q  <= addr_cnt_d;
      rdaddress_q <= rdaddress_d;
      ctl_s1_q    <= ctl_s1_d;
      de_q        <= de_d;
      fs_q        <= fs_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
    end
  end

  assign rdaddress   = rdaddress_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_scanout.sv
// Scoreboard bench: instance A uses the real 640x480 timing (active-low
// sync), instance B a miniature raster (active-high sync) so whole frames fit.
module tb_hdmi_scanout;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
  } exp_t;

  localparam int HA  [2] = '{640, 8};
  localparam int HFP [2] = '{16, 2};
  localparam int HSW [2] = '{96, 3};
  localparam int HBP [2] = '{48, 3};
  localparam int VA  [2] = '{480, 6};
  localparam int VFP [2] = '{10, 1};
  localparam int VSW [2] = '{2, 2};
  localparam int VBP [2] = '{33, 2};
  localparam bit POL [2] = '{1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [18:0] a_addr, b_addr;
  logic [8:0]  a_rd, b_rd;
  logic [7:0]  a_red, a_green, a_blue, b_red, b_green, b_blue;
  logic        a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;

  hdmi_scanout #(.SYNC_POL(1'b0), .ADDR_W(19)) u_a (
    .rdclk(clk), .reset(rst), .rdaddress(a_addr), .read_data(a_rd),
    .red(a_red), .green(a_green), .blue(a_blue),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .frame_start(a_fs)
  );

  hdmi_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .ADDR_W(19)
  ) u_b (
    .rdclk(clk), .reset(rst), .rdaddress(b_addr), .read_data(b_rd),
    .red(b_red), .green(b_green), .blue(b_blue),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .frame_start(b_fs)
  );

  // Frame buffer model with one-clock registered read
  logic [8:0] mem [0:307199];
  always @(posedge clk) begin
    a_rd <= mem[a_addr];
    b_rd <= mem[b_addr];
  end

  int   vectors = 0;
  int   miscompares = 0;
  exp_t qa[$];
  exp_t qb[$];
  bit   mon_on = 1'b0;
  int   cyc;
  int   de_rise_t, de_fall_t, hs_fall_t, vs_rise_t, fs_t;
  logic prev_de, prev_hs, prev_vs;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Nearest 8-bit level to c/7 of full scale
  function automatic logic [7:0] x8(input logic [2:0] c);
    return 8'((int'(c) * 510 + 7) / 14);
  endfunction

  function automatic exp_t idle(input int s);
    exp_t e;
    e    = '0;
    e.hs = !POL[s];
    e.vs = !POL[s];
    return e;
  endfunction

  // Expected output for the n-th raster position after reset release
  function automatic exp_t model(input int s, input int n);
    int ht, vt, h, v;
    bit act;
    logic [8:0] pix;
    exp_t e;
    ht  = HA[s] + HFP[s] + HSW[s] + HBP[s];
    vt  = VA[s] + VFP[s] + VSW[s] + VBP[s];
    h   = n % ht;
    v   = (n / ht) % vt;
    act = (h < HA[s]) && (v < VA[s]);
    pix = act ? mem[v * HA[s] + h] : 9'h0;
    e.r  = act ? x8(pix[8:6]) : 8'h00;
    e.g  = act ? x8(pix[5:3]) : 8'h00;
    e.b  = act ? x8(pix[2:0]) : 8'h00;
    e.hs = (h >= HA[s] + HFP[s] && h < HA[s] + HFP[s] + HSW[s]) ? POL[s] : !POL[s];
    e.vs = (v >= VA[s] + VFP[s] && v < VA[s] + VFP[s] + VSW[s]) ? POL[s] : !POL[s];
    e.de = act;
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  function automatic int model_addr(input int s, input int n);
    int ht, vt, h, v;
    ht = HA[s] + HFP[s] + HSW[s] + HBP[s];
    vt = VA[s] + VFP[s] + VSW[s] + VBP[s];
    h  = n % ht;
    v  = (n / ht) % vt;
    return ((h < HA[s]) && (v < VA[s])) ? v * HA[s] + h : 0;
  endfunction

  task automatic check_idle(input string tag);
    exp_t ga, gb;
    ga = '{a_red, a_green, a_blue, a_hs, a_vs, a_de, a_fs};
    gb = '{b_red, b_green, b_blue, b_hs, b_vs, b_de, b_fs};
    chk({"A.", tag, ".out"}, ga, idle(0));
    chk({"A.", tag, ".addr"}, a_addr, 0);
    chk({"B.", tag, ".out"}, gb, idle(1));
    chk({"B.", tag, ".addr"}, b_addr, 0);
  endtask

  // Release reset and issue `cycles` raster positions; returns on the
  // falling edge where position `cycles` is held.
  task automatic run(input int cycles);
    rst = 1'b0;
    qa.delete();
    qb.delete();
    qa.push_back(idle(0));
    qb.push_back(idle(1));
    cyc = 0;
    de_rise_t = -1; de_fall_t = -1; hs_fall_t = -1; vs_rise_t = -1; fs_t = -1;
    prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b0;
    mon_on = 1'b1;
    for (int n = 0; n < cycles; n++) begin
      qa.push_back(model(0, n));
      qb.push_back(model(1, n));
      chk("A.rdaddress", a_addr, model_addr(0, n));
      chk("B.rdaddress", b_addr, model_addr(1, n));
      @(negedge clk);
    end
  endtask

  // Monitor: one output word per clock once running
  always begin
    exp_t ga, gb, e;
    @(posedge clk);
    #1;
    if (mon_on) begin
      cyc++;
      ga = '{a_red, a_green, a_blue, a_hs, a_vs, a_de, a_fs};
      gb = '{b_red, b_green, b_blue, b_hs, b_vs, b_de, b_fs};
      if (qa.size() == 0) chk("A.queue_empty", 1, 0);
      else begin e = qa.pop_front(); chk("A.pixel", ga, e); end
      if (qb.size() == 0) chk("B.queue_empty", 1, 0);
      else begin e = qb.pop_front(); chk("B.pixel", gb, e); end

      if (a_de && !prev_de) begin
        if (de_rise_t < 0) begin
          chk("A.first_de_edge", cyc, 2);
          chk("A.first_frame_start", a_fs, 1);
        end else begin
          chk("A.de_low_len", cyc - de_fall_t, 160);
        end
        de_rise_t = cyc;
      end
      if (!a_de && prev_de) begin
        chk("A.de_high_len", cyc - de_rise_t, 640);
        de_fall_t = cyc;
      end
      if (!a_hs && prev_hs) begin
        chk("A.hsync_after_de", cyc - de_fall_t, 16);
        hs_fall_t = cyc;
      end
      if (a_hs && !prev_hs) chk("A.hsync_len", cyc - hs_fall_t, 96);
      if (b_vs && !prev_vs) vs_rise_t = cyc;
      if (!b_vs && prev_vs) chk("B.vsync_len", cyc - vs_rise_t, 32);
      if (b_fs) begin
        if (fs_t >= 0) chk("B.frame_period", cyc - fs_t, 176);
        fs_t = cyc;
      end
      prev_de = a_de;
      prev_hs = a_hs;
      prev_vs = b_vs;
    end
  end

  initial begin
    for (int i = 0; i < 307200; i++) mem[i] = 9'($urandom);
    for (int i = 640; i < 1280; i++) mem[i] = 9'b111_000_101;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");

    run(300);
    #2 rst = 1'b1;
    mon_on = 1'b0;
    #1 check_idle("midline_reset");
    repeat (3) @(negedge clk);
    check_idle("held_reset");

    run(2400);
    mon_on = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
